// File: rtl/dii_packet_arbiter.sv
// rtl/dii_packet_arbiter.sv - packet-granular round-robin arbiter merging N DII channels
module dii_packet_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_first,
  input  logic [N-1:0]       in_last,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_first,
  output logic               out_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       grant
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state, state_n;
  logic [N-1:0]  grant_n;
  logic [IW-1:0] last_grant, last_grant_n;
  logic [IW-1:0] grant_idx;
  logic [N-1:0]  winner;
  logic          found;
  logic          release_pkt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IW'(N - 1);
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      last_grant <= last_grant_n;
    end
  end

  // grant is all-zero outside LOCKED, so the AND-OR mux also yields the idle zeros
  always_comb begin
    out_data  = '0;
    out_first = 1'b0;
    out_last  = 1'b0;
    out_valid = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        out_data  = in_data[i*WIDTH +: WIDTH];
        out_first = in_first[i];
        out_last  = in_last[i];
        out_valid = in_valid[i];
        grant_idx = IW'(i);
      end
    end
    in_ready = grant & {N{out_ready}};
  end

  // Scan upward from the input after the last winner, wrapping around
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && in_valid[(int'(last_grant) + k) % N]) begin
        winner[(int'(last_grant) + k) % N] = 1'b1;
        found = 1'b1;
      end
    end
  end

  assign release_pkt = out_valid & out_ready & out_last;

  always_comb begin
    state_n      = state;
    grant_n      = grant;
    last_grant_n = last_grant;
    case (state)
      IDLE: begin
        if (|in_valid) begin
          state_n = LOCKED;
          grant_n = winner;
        end
      end
      LOCKED: begin
        if (release_pkt) begin
          state_n      = IDLE;
          grant_n      = '0;
          last_grant_n = grant_idx;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_dii_packet_arbiter.sv
// tb/tb_dii_packet_arbiter.sv - scoreboard testbench for dii_packet_arbiter
module tb_dii_packet_arbiter;

  localparam int N     = 4;
  localparam int WIDTH = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_first;
  logic [N-1:0]       in_last;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_first;
  logic               out_last;
  logic               out_valid;
  logic               out_ready;
  logic [N-1:0]       grant;

  dii_packet_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_first  (in_first),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_first (out_first),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant     (grant)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]     g;
    logic             f;
    logic             l;
    logic [WIDTH-1:0] d;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH+1:0] src_mem [N][64];
  int               src_wr [N];
  int               src_rd [N];
  logic [N-1:0]     src_en;
  int               checks = 0;
  int               errors = 0;
  int               n_xfer = 0;
  int               cyc    = 0;
  int               xcyc [256];
  int               n0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (src_rd[i] != src_wr[i] && src_en[i]) begin
        {in_first[i], in_last[i], in_data[i*WIDTH +: WIDTH]} = src_mem[i][src_rd[i]];
        in_valid[i] = 1'b1;
      end else begin
        in_first[i] = 1'b0;
        in_last[i]  = 1'b0;
        in_data[i*WIDTH +: WIDTH] = '0;
        in_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic load_pkt(input int ch, input logic [WIDTH-1:0] base, input int len);
    for (int k = 0; k < len; k++) begin
      src_mem[ch][src_wr[ch]] = {(k == 0), (k == len - 1), base + WIDTH'(k)};
      src_wr[ch]++;
    end
  endtask

  task automatic expect_pkt(input logic [N-1:0] g, input logic [WIDTH-1:0] base,
                            input int k0, input int k1, input int len);
    for (int k = k0; k <= k1; k++)
      exp_q.push_back({g, (k == 0), (k == len - 1), base + WIDTH'(k)});
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_xfer(input int target, input int budget);
    int b = 0;
    while (n_xfer < target && b < budget) begin
      step();
      b++;
    end
    chk("xfer_timeout", 64'(n_xfer >= target), 64'd1);
  endtask

  task automatic wait_drain(input int budget);
    int b = 0;
    while (exp_q.size() != 0 && b < budget) begin
      step();
      b++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // Upstream sources: pop a flit after each accepted handshake
  initial begin
    logic [N-1:0] fire;
    forever begin
      @(negedge clk);
      fire = in_valid & in_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
        if (fire[i]) src_rd[i]++;
      drive();
    end
  end

  // Downstream monitor: every accepted output flit is matched against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (out_valid && out_ready) begin
        xcyc[n_xfer % 256] = cyc;
        n_xfer++;
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL unexpected_flit observed %h expected none", out_data);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checks++;
          assert ({grant, out_first, out_last, out_data} === e && in_ready === e.g) else begin
            errors++;
            $error("FAIL out_flit observed g=%b rdy=%b f=%b l=%b d=%h expected g=%b f=%b l=%b d=%h",
                   grant, in_ready, out_first, out_last, out_data, e.g, e.f, e.l, e.d);
          end
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    out_ready = 1'b0;
    src_en    = '1;
    drive();
    @(posedge clk);
    #2;
    @(negedge clk);
    chk("reset_outputs", {grant, in_ready, out_valid, out_first, out_last, out_data}, 64'd0);
    step();
    rst       = 1'b0;
    out_ready = 1'b1;

    // Reset priority: round robin from input 0
    n0 = n_xfer;
    load_pkt(0, 16'h0A00, 1);
    load_pkt(0, 16'h0A01, 1);
    load_pkt(1, 16'h0B00, 1);
    load_pkt(2, 16'h0C00, 1);
    load_pkt(3, 16'h0D00, 1);
    expect_pkt(4'b0001, 16'h0A00, 0, 0, 1);
    expect_pkt(4'b0010, 16'h0B00, 0, 0, 1);
    expect_pkt(4'b0100, 16'h0C00, 0, 0, 1);
    expect_pkt(4'b1000, 16'h0D00, 0, 0, 1);
    expect_pkt(4'b0001, 16'h0A01, 0, 0, 1);
    drive();
    wait_drain(40);
    chk("rr_spacing", 64'(xcyc[(n0 + 4) % 256] - xcyc[n0 % 256]), 64'd8);

    // No interleave: input 1 packet completes before input 2
    load_pkt(1, 16'h1A01, 3);
    load_pkt(2, 16'h2B00, 1);
    expect_pkt(4'b0010, 16'h1A01, 0, 2, 3);
    expect_pkt(4'b0100, 16'h2B00, 0, 0, 1);
    drive();
    wait_drain(40);

    // Backpressure mid-packet on input 0
    n0 = n_xfer;
    load_pkt(0, 16'h3C01, 4);
    expect_pkt(4'b0001, 16'h3C01, 0, 3, 4);
    drive();
    wait_xfer(n0 + 1, 20);
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_stall", {grant, in_ready, out_valid, out_first, out_last, out_data},
          {4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 16'h3C02});
    end
    step();
    out_ready = 1'b1;
    wait_drain(40);

    // Valid gap on locked input 3 while input 0 waits
    n0 = n_xfer;
    load_pkt(3, 16'h4E01, 3);
    load_pkt(0, 16'h4F00, 1);
    expect_pkt(4'b1000, 16'h4E01, 0, 2, 3);
    expect_pkt(4'b0001, 16'h4F00, 0, 0, 1);
    drive();
    wait_xfer(n0 + 1, 20);
    src_en[3] = 1'b0;
    drive();
    repeat (2) begin
      @(negedge clk);
      chk("gap_hold", {grant, out_valid, in_ready[0]}, {4'b1000, 1'b0, 1'b0});
      step();
    end
    src_en[3] = 1'b1;
    drive();
    wait_drain(40);

    // Reset during flit 2 of a 4-flit packet on input 2
    n0 = n_xfer;
    load_pkt(2, 16'h5C01, 4);
    expect_pkt(4'b0100, 16'h5C01, 0, 1, 4);
    expect_pkt(4'b0001, 16'h5D00, 0, 0, 1);
    expect_pkt(4'b0100, 16'h5C01, 2, 3, 4);
    drive();
    wait_xfer(n0 + 1, 20);
    rst = 1'b1;
    load_pkt(0, 16'h5D00, 1);
    drive();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_clear", {grant, out_valid, in_ready}, 64'd0);
    wait_drain(40);

    // Throughput: 2-flit packets from one input
    n0 = n_xfer;
    load_pkt(1, 16'h6100, 2);
    load_pkt(1, 16'h6110, 2);
    load_pkt(1, 16'h6120, 2);
    expect_pkt(4'b0010, 16'h6100, 0, 1, 2);
    expect_pkt(4'b0010, 16'h6110, 0, 1, 2);
    expect_pkt(4'b0010, 16'h6120, 0, 1, 2);
    drive();
    wait_drain(40);
    chk("thru_count", 64'(n_xfer - n0), 64'd6);
    chk("thru_span", 64'(xcyc[(n0 + 5) % 256] - xcyc[n0 % 256]), 64'd7);

    repeat (3) step();
    chk("no_extra_flits", 64'(n_xfer - n0), 64'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dii_packet_arbiter.md
# dii_packet_arbiter

Packet-granular round-robin arbiter that merges N Debug Interconnect Interface (DII) request channels onto one DII output channel. It sits in front of a `dii_buffer` or a router port where several debug modules share one link toward the host. Once a packet from an input wins, the arbiter locks onto that input until the packet's `last` flit is accepted, so packets are never interleaved.

## Interface
Parameters:
- `N`, 4: number of input channels, ≥2.
- `WIDTH`, 16: flit data width.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  N*WIDTH  input flit data; channel i occupies bits [i*WIDTH +: WIDTH].
- `in_first`  in  N  per-channel first-flit marker.
- `in_last`  in  N  per-channel last-flit marker.
- `in_valid`  in  N  per-channel flit valid.
- `in_ready`  out  N  per-channel ready; at most one bit is set.
- `out_data`  out  WIDTH  merged flit data.
- `out_first`  out  1  merged first marker.
- `out_last`  out  1  merged last marker.
- `out_valid`  out  1  merged valid.
- `out_ready`  in  1  downstream ready.
- `grant`  out  N  one-hot index of the locked input; all zero in IDLE.

## Operation
- A flit transfers on a channel when `valid & ready` are both high in the same cycle.
- Two states: IDLE and LOCKED. The arbiter also holds a registered `grant` and a registered `last_grant` index.
- IDLE:
  - `out_valid`=0, `in_ready`=0, and out_data/first/last=0.
  - If any `in_valid` bit is set, select the first set bit scanning upward from `(last_grant+1) mod N` with wrap-around.
  - Load `grant` with the one-hot winner and go to LOCKED. The winner is selected regardless of `in_first`; upstream guarantees packet framing.
  - If no input is valid, stay in IDLE.
- LOCKED, with granted index g:
  - `out_data`/`out_first`/`out_last`/`out_valid` equal input g's fields.
  - `in_ready[g]` = `out_ready`; all other `in_ready` bits are 0. The merged path is purely combinational.
  - A transfer with `in_last[g]`=1 moves to IDLE next cycle, sets `last_grant`<=g and clears `grant`.
  - A transfer with `last`=0, or no transfer, stays in LOCKED.
  - Deasserting `in_valid[g]` mid-packet keeps the lock; the arbiter waits.
- A single-flit packet (first=last=1) locks for exactly the cycles up to and including its accept.
- Non-granted inputs are never acknowledged, and their flits are never dropped or reordered.
- Reset:
  - State goes to IDLE, `grant` to 0 and `last_grant` to N-1, so input 0 has highest priority after reset.
  - All outputs are 0 in the cycle after `rst` is sampled high.
  - Reset mid-packet drops the lock; the remainder of that packet is treated as a fresh request. Truncation is the upstream's concern.

## Timing
- Arbitration costs one bubble cycle per packet. With `in_valid` and `out_ready` constantly high, each packet of L flits occupies L+1 cycles: one IDLE cycle plus L LOCKED cycles.
- `grant`, state and `last_grant` are registered.
- `out_*` and `in_ready` are combinational from `grant` and the inputs; there is no added data latency.
- `out_valid` depends on `in_valid[g]`. `in_ready[g]` depends on `out_ready`. No combinational path exists from `out_ready` to `out_valid`.
- Requests appearing in the same cycle as a release (last accepted) are not considered until the next cycle, when the arbiter is back in IDLE.
- Fairness: with all N inputs continuously requesting, each input wins exactly once every N packets.

## Test plan
- **Reset priority:** after reset, raise all four `in_valid` with 1-flit packets and hold `out_ready`=1 → `grant` sequence is 0001, 0010, 0100, 1000, 0001, and each output packet appears on the cycle after its grant.
- **No interleave:** input 1 sends a 3-flit packet (data A1..A3) while input 2 is valid throughout → `out_data` is A1, A2, A3 consecutively, `in_ready[2]`=0 until the cycle after A3 is accepted, then input 2 is granted.
- **Backpressure:** locked on input 0, hold `out_ready`=0 for 5 cycles mid-packet → `in_ready[0]`=0 for those cycles, output data and markers stay stable, and no flit is lost or duplicated.
- **Gap in grant:** locked on input 3, drop `in_valid[3]` for 2 cycles mid-packet while input 0 is valid → `grant` stays 1000, `out_valid`=0 during the gap, and input 0 is not acknowledged.
- **Mid-packet reset:** assert `rst` for 1 cycle during flit 2 of a 4-flit packet on input 2 → next cycle `grant`=0, `out_valid`=0, all `in_ready`=0, and the following arbitration starts at input 0.
- **Throughput:** a single input streams 2-flit packets with `out_ready`=1 → exactly 2 flits accepted per 3 cycles.
